// File: rtl/cayde_lsu_ctrl.sv
// Load/store sequencer: execute-stage request -> mem_req/gnt/rvalid bus, one op in flight.
// Optional WAIT-state bus timeout is compiled in with `define CAYDE_LSU_TIMEOUT_EN.
module cayde_lsu_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_load_op_i,
  input  logic [1:0]        lsu_store_op_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic              lsu_busy_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [1:0] OP_BYTE = 2'd0;
  localparam logic [1:0] OP_HALF = 2'd1;
  localparam logic [1:0] OP_WORD = 2'd2;

  state_t            state_q;
  logic              we_q;
  logic [1:0]        op_q;
  logic [1:0]        off_q;
  logic              ready_q, busy_q, done_q, err_q;
  logic [31:0]       rdata_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  // Decode of the request presented at the execute-stage port
  logic [1:0]  op_d;
  logic        ok_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_data_d;

  always_comb begin
    op_d    = lsu_we_i ? lsu_store_op_i : lsu_load_op_i;
    ok_d    = 1'b0;
    be_d    = 4'b0000;
    wdata_d = lsu_wdata_i;
    case (op_d)
      OP_BYTE: begin
        ok_d    = 1'b1;
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      OP_HALF: begin
        ok_d    = ~lsu_addr_i[0];
        be_d    = 4'b0011 << lsu_addr_i[1:0];
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      OP_WORD: begin
        ok_d    = (lsu_addr_i[1:0] == 2'b00);
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
      end
      default: ok_d = 1'b0;
    endcase
  end

  // Zero-extended lane extraction using the captured op and byte offset
  always_comb begin
    ld_data_d = mem_rdata_i;
    case (op_q)
      OP_BYTE: ld_data_d = {24'h0, mem_rdata_i[8*off_q +: 8]};
      OP_HALF: ld_data_d = {16'h0, mem_rdata_i[16*off_q[1] +: 16]};
      default: ld_data_d = mem_rdata_i;
    endcase
  end

`ifdef CAYDE_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      op_q        <= 2'b00;
      off_q       <= 2'b00;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
`ifdef CAYDE_LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (lsu_valid_i && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            we_q    <= lsu_we_i;
            op_q    <= op_d;
            off_q   <= lsu_addr_i[1:0];
            if (ok_d) begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= lsu_we_i;
              mem_addr_q  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end else begin
              // Misaligned or illegal: complete with error, never touch the bus
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            state_q   <= WAIT;
            mem_req_q <= 1'b0;
`ifdef CAYDE_LSU_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            err_q   <= mem_err_i;
            rdata_q <= (we_q || mem_err_i) ? 32'h0 : ld_data_d;
          end
`ifdef CAYDE_LSU_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_ready_o = ready_q;
  assign lsu_busy_o  = busy_q;
  assign lsu_done_o  = done_q;
  assign lsu_err_o   = err_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_cayde_lsu_ctrl.sv
// Directed bench for cayde_lsu_ctrl: inputs change on the falling edge, outputs checked there too.
module tb_cayde_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i, lsu_ready_o, lsu_we_i;
  logic [1:0]  lsu_load_op_i, lsu_store_op_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic        lsu_done_o, lsu_err_o, lsu_busy_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        mem_rvalid_i, mem_err_i;

  int n_chk  = 0;
  int n_fail = 0;
  int seen;

  always #5 clk = ~clk;

  cayde_lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_we_i(lsu_we_i),
    .lsu_load_op_i(lsu_load_op_i), .lsu_store_op_i(lsu_store_op_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o),
    .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o), .lsu_busy_o(lsu_busy_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accepting edge
  task automatic issue(input logic we, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    lsu_valid_i    = 1'b1;
    lsu_we_i       = we;
    lsu_load_op_i  = we ? 2'd0 : op;
    lsu_store_op_i = we ? op : 2'd0;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
    step();
    lsu_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lsu_valid_i = 0; lsu_we_i = 0; lsu_load_op_i = 0; lsu_store_op_i = 0;
    lsu_addr_i = 0; lsu_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    mem_rdata_i = 0; mem_err_i = 0;
    repeat (2) step();
    chk("rst_ready", lsu_ready_o, 0);
    chk("rst_busy",  lsu_busy_o, 0);
    chk("rst_done",  lsu_done_o, 0);
    chk("rst_req",   mem_req_o, 0);
    chk("rst_be",    mem_be_o, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", lsu_ready_o, 1);

    // LW 0x100, grant immediately, response next cycle
    issue(0, 2'd2, 32'h100, 0);
    chk("lw_req",   mem_req_o, 1);
    chk("lw_addr",  mem_addr_o, 32'h100);
    chk("lw_be",    mem_be_o, 4'hF);
    chk("lw_we",    mem_we_o, 0);
    chk("lw_busy",  lsu_busy_o, 1);
    chk("lw_ready", lsu_ready_o, 0);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    chk("lw_req_drop", mem_req_o, 0);
    chk("lw_nodone",   lsu_done_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; step(); mem_rvalid_i = 0;
    chk("lw_done",  lsu_done_o, 1);
    chk("lw_rdata", lsu_rdata_o, 32'hDEADBEEF);
    chk("lw_err",   lsu_err_o, 0);
    step();
    chk("lw_pulse", lsu_done_o, 0);
    chk("lw_ready_back", lsu_ready_o, 1);

    // LBU 0x103: top byte lane, zero-extended
    issue(0, 2'd0, 32'h103, 0);
    chk("lbu_be",   mem_be_o, 4'b1000);
    chk("lbu_addr", mem_addr_o, 32'h100);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h80FF_0000; step(); mem_rvalid_i = 0;
    chk("lbu_done",  lsu_done_o, 1);
    chk("lbu_rdata", lsu_rdata_o, 32'h0000_0080);
    chk("lbu_err",   lsu_err_o, 0);
    step();

    // SH 0x202 with grant held off three cycles; a second request must be ignored
    issue(1, 2'd1, 32'h202, 32'h1234_ABCD);
    chk("sh_req",   mem_req_o, 1);
    chk("sh_we",    mem_we_o, 1);
    chk("sh_be",    mem_be_o, 4'b1100);
    chk("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
    chk("sh_addr",  mem_addr_o, 32'h200);
    issue(0, 2'd2, 32'h300, 0);
    chk("sh_hold_req",  mem_req_o, 1);
    chk("sh_hold_addr", mem_addr_o, 32'h200);
    chk("sh_hold_be",   mem_be_o, 4'b1100);
    step();
    chk("sh_hold_req2", mem_req_o, 1);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    chk("sh_req_drop", mem_req_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF; step(); mem_rvalid_i = 0;
    chk("sh_done",  lsu_done_o, 1);
    chk("sh_rdata", lsu_rdata_o, 0);
    chk("sh_err",   lsu_err_o, 0);
    step();

    // Misaligned LW: error at T+1, bus untouched
    issue(0, 2'd2, 32'h101, 0);
    chk("mis_done", lsu_done_o, 1);
    chk("mis_err",  lsu_err_o, 1);
    chk("mis_req",  mem_req_o, 0);
    chk("mis_rdata", lsu_rdata_o, 0);
    step();
    chk("mis_pulse", lsu_done_o, 0);
    chk("mis_ready", lsu_ready_o, 1);

    // Illegal store op 3
    issue(1, 2'd3, 32'h400, 32'h5);
    chk("ill_done", lsu_done_o, 1);
    chk("ill_err",  lsu_err_o, 1);
    chk("ill_req",  mem_req_o, 0);
    step();

    // Stray rvalid while idle is ignored
    mem_rvalid_i = 1; step(); mem_rvalid_i = 0;
    chk("stray_rvalid", lsu_done_o, 0);

    // Bus error response
    issue(0, 2'd2, 32'h104, 0);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'h55; step();
    mem_rvalid_i = 0; mem_err_i = 0;
    chk("berr_done",  lsu_done_o, 1);
    chk("berr_err",   lsu_err_o, 1);
    chk("berr_rdata", lsu_rdata_o, 0);
    step();

    // Reset while in WAIT, response arrives late
    issue(0, 2'd2, 32'h108, 0);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    chk("rw_busy", lsu_busy_o, 1);
    rst = 1; step(); rst = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h1; step(); mem_rvalid_i = 0;
    chk("rw_done",  lsu_done_o, 0);
    chk("rw_ready", lsu_ready_o, 1);
    chk("rw_busy0", lsu_busy_o, 0);
    step();
    chk("rw_done2", lsu_done_o, 0);

    // No response at all
    issue(0, 2'd2, 32'h10C, 0);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
`ifdef CAYDE_LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_early", lsu_done_o, 0);
    end
    step();
    chk("to_done", lsu_done_o, 1);
    chk("to_err",  lsu_err_o, 1);
    step();
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (lsu_done_o) seen++;
    end
    chk("hang_nodone", seen, 0);
    chk("hang_busy", lsu_busy_o, 1);
    rst = 1; step(); rst = 0; step();
`endif
    chk("end_ready", lsu_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
